acc_dispatch_ctrl: RTL and testbench

Parametrised accelerator dispatch controller; successor to the fixed three-accelerator top-level control array.
- Decodes accelerator instructions from the communication interface and enables exactly one of NUM_ACC accelerators.
- Tracks each job's read/write completion and reports done through a level/acknowledge handshake.
- Sits between the instruction bus interface and the accelerator bank (FFT/FIR/IIR and later additions).

---
 rtl/acc_dispatch_pkg.sv | 21 ++
 rtl/acc_dispatch_ctrl_if.sv | 21 ++
 rtl/acc_dispatch_wdog.sv | 34 +++
 rtl/acc_dispatch_ctrl.sv | 139 +++++++++++++
 tb/tb_acc_dispatch_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_dispatch_pkg.sv
// Shared types and constants for the accelerator dispatch controller.
// Build option: ACC_DISPATCH_TIMEOUT_EN enables the job watchdog.
package acc_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int          OPC_MSB        = 31;
  localparam int          OPC_LSB        = 26;
  localparam logic [5:0]  DEFAULT_OPCODE = 6'h3F;

  // A single channel still needs a 1-bit index field.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_dispatch_ctrl_if.sv
// Instruction-bus side of the dispatch controller: select, bypass and the
// valid/ready instruction handshake.
interface acc_dispatch_ctrl_if;

  logic        chipselect;
  logic        acc_bypass;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;

  modport master (
    output chipselect, acc_bypass, instr_valid, instruction,
    input  instr_ready
  );

  modport slave (
    input  chipselect, acc_bypass, instr_valid, instruction,
    output instr_ready
  );

endinterface

// File: rtl/acc_dispatch_wdog.sv
// Job watchdog: counts cycles of an active job and flags expiry at
// TIMEOUT_CYCLES-1. Only elaborated when ACC_DISPATCH_TIMEOUT_EN is defined.
module acc_dispatch_wdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic srst_i,
  input  logic start_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int            CW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Cycle counter, restarted each time a job is launched.
  always_ff @(posedge clk) begin
    if (!reset || srst_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
    end else if (run_i && !expire_o) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expire_o = run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/acc_dispatch_ctrl.sv
// Accelerator dispatch controller: decodes accelerator instructions, enables one
// of NUM_ACC channels and tracks read/write completion. Build option:
// ACC_DISPATCH_TIMEOUT_EN adds a per-job watchdog (timeout_err otherwise 0).
module acc_dispatch_ctrl
  import acc_dispatch_pkg::*;
#(
  parameter int         NUM_ACC        = 3,
  parameter logic [5:0] OPCODE         = DEFAULT_OPCODE,
  parameter int         CNT_W          = 8,
  parameter int         TIMEOUT_CYCLES = 4096,
  localparam int        IDX_W          = idx_width(NUM_ACC)
) (
  input  logic                 clk,
  input  logic                 reset,
  acc_dispatch_ctrl_if.slave   bus,
  input  logic [NUM_ACC-1:0]   read_done,
  input  logic [NUM_ACC-1:0]   write_done,
  input  logic                 done_ack,
  output logic [NUM_ACC-1:0]   acc_enable,
  output logic                 acc_done,
  output logic                 busy,
  output logic [IDX_W-1:0]     active_idx,
  output logic                 err,
  output logic [CNT_W-1:0]     done_count,
  output logic                 timeout_err
);

  state_e             state_q;
  logic [NUM_ACC-1:0] acc_enable_q;
  logic               acc_done_q;
  logic               busy_q;
  logic [IDX_W-1:0]   active_idx_q;
  logic               err_q;
  logic [CNT_W-1:0]   done_count_q;
  logic               timeout_err_q;

  logic [5:0]         opc_s;
  logic [IDX_W-1:0]   dec_idx_s;
  logic               dec_ok_s;
  logic               accept_s;
  logic [NUM_ACC-1:0] onehot_s;
  logic               rd_s;
  logic               wr_s;
  logic               expire_s;

  // Reserved bits [25:IDX_W] must be zero, so out-of-width indices are rejected too.
  assign opc_s     = bus.instruction[OPC_MSB:OPC_LSB];
  assign dec_idx_s = bus.instruction[IDX_W-1:0];
  assign dec_ok_s  = (opc_s == OPCODE) && bus.acc_bypass &&
                     (bus.instruction[OPC_LSB-1:IDX_W] == '0) &&
                     ({1'b0, dec_idx_s} < (IDX_W+1)'(NUM_ACC));
  assign accept_s  = (state_q == ST_IDLE) && bus.instr_valid && dec_ok_s;
  assign onehot_s  = {{(NUM_ACC-1){1'b0}}, 1'b1} << dec_idx_s;

  assign rd_s = read_done[active_idx_q];
  assign wr_s = write_done[active_idx_q];

`ifdef ACC_DISPATCH_TIMEOUT_EN
  acc_dispatch_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .srst_i   (!bus.chipselect),
    .start_i  (accept_s),
    .run_i    (busy_q),
    .expire_o (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // Dispatch FSM with all outputs registered; reset outranks chipselect.
  always_ff @(posedge clk) begin
    if (!reset || !bus.chipselect) begin
      state_q       <= ST_IDLE;
      acc_enable_q  <= '0;
      acc_done_q    <= 1'b0;
      busy_q        <= 1'b0;
      active_idx_q  <= '0;
      err_q         <= 1'b0;
      done_count_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            if (accept_s) begin
              active_idx_q <= dec_idx_s;
              acc_enable_q <= onehot_s;
              busy_q       <= 1'b1;
              state_q      <= ST_RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_RUN, ST_WRITE: begin
          if (wr_s && (rd_s || state_q == ST_WRITE)) begin
            acc_enable_q <= '0;
            busy_q       <= 1'b0;
            acc_done_q   <= 1'b1;
            done_count_q <= done_count_q + CNT_W'(1);
            state_q      <= ST_DONE;
          end else if (rd_s && state_q == ST_RUN) begin
            state_q <= ST_WRITE;
          end else if (wr_s || expire_s) begin
            // Write before read is a protocol error; expiry is a watchdog abort.
            acc_enable_q <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b1;
            timeout_err_q <= timeout_err_q | (expire_s & ~wr_s);
            state_q      <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (done_ack) begin
            acc_done_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign acc_enable      = acc_enable_q;
  assign acc_done        = acc_done_q;
  assign busy            = busy_q;
  assign active_idx      = active_idx_q;
  assign err             = err_q;
  assign done_count      = done_count_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_acc_dispatch_ctrl.sv
// Scoreboard bench for acc_dispatch_ctrl (NUM_ACC=4, TIMEOUT_CYCLES=16); the
// watchdog section depends on ACC_DISPATCH_TIMEOUT_EN.
module tb_acc_dispatch_ctrl;

  localparam int EV_EN   = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int         kind;
    logic [3:0] en;
    logic [1:0] idx;
    logic [7:0] cnt;
    logic       tmo;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] read_done, write_done;
  logic       done_ack;
  logic [3:0] acc_enable;
  logic       acc_done, busy, err, timeout_err;
  logic [1:0] active_idx;
  logic [7:0] done_count;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  acc_dispatch_ctrl_if bus ();

  acc_dispatch_ctrl #(
    .NUM_ACC        (4),
    .OPCODE         (6'h3F),
    .CNT_W          (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .read_done   (read_done),
    .write_done  (write_done),
    .done_ack    (done_ack),
    .acc_enable  (acc_enable),
    .acc_done    (acc_done),
    .busy        (busy),
    .active_idx  (active_idx),
    .err         (err),
    .done_count  (done_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_en(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    exp_q.push_back('{EV_EN, oh, idx, 8'd0, 1'b0});
  endtask

  task automatic push_done(input logic [7:0] cnt);
    exp_q.push_back('{EV_DONE, 4'b0000, 2'd0, cnt, 1'b0});
  endtask

  task automatic push_err(input logic tmo);
    exp_q.push_back('{EV_ERR, 4'b0000, 2'd0, 8'd0, tmo});
  endtask

  task automatic send(input logic [31:0] ins);
    bus.instruction = ins;
    bus.instr_valid = 1'b1;
    cyc(1);
    bus.instr_valid = 1'b0;
    bus.instruction = 32'h0000_0000;
  endtask

  // Full job with simultaneous read/write completion, then acknowledge.
  task automatic run_job(input logic [1:0] idx, input logic [7:0] cnt);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    push_en(idx);
    send(32'hFC00_0000 | {30'd0, idx});
    push_done(cnt);
    read_done  = oh;
    write_done = oh;
    cyc(1);
    read_done  = 4'b0000;
    write_done = 4'b0000;
    done_ack   = 1'b1;
    cyc(1);
    done_ack   = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_en"},   {28'd0, acc_enable}, 32'h0);
    chk({name, "_done"}, {31'd0, acc_done},   32'h0);
    chk({name, "_busy"}, {31'd0, busy},       32'h0);
    chk({name, "_idx"},  {30'd0, active_idx}, 32'h0);
    chk({name, "_err"},  {31'd0, err},        32'h0);
    chk({name, "_cnt"},  {24'd0, done_count}, 32'h0);
    chk({name, "_tmo"},  {31'd0, timeout_err}, 32'h0);
  endtask

  // Monitor: every enable rise, done rise or err cycle consumes one expectation.
  logic [3:0] prev_en   = 4'b0000;
  logic       prev_done = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (reset === 1'b1) begin
      if (err) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_err actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("err_kind", e.kind, EV_ERR);
          chk("err_en", {28'd0, acc_enable}, {28'd0, e.en});
          chk("err_tmo", {31'd0, timeout_err}, {31'd0, e.tmo});
        end
      end
      if (acc_enable != 4'b0000 && prev_en == 4'b0000) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_enable actual=%0h required=0", acc_enable);
        end else begin
          e = exp_q.pop_front();
          chk("en_kind", e.kind, EV_EN);
          chk("en_onehot", {28'd0, acc_enable}, {28'd0, e.en});
          chk("en_idx", {30'd0, active_idx}, {30'd0, e.idx});
        end
      end
      if (acc_done && !prev_done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("done_kind", e.kind, EV_DONE);
          chk("done_count", {24'd0, done_count}, {24'd0, e.cnt});
          chk("done_en", {28'd0, acc_enable}, 32'h0);
          chk("done_busy", {31'd0, busy}, 32'h0);
        end
      end
    end
    prev_en   = acc_enable;
    prev_done = acc_done;
  end

  initial begin
    reset = 1'b0;
    bus.chipselect  = 1'b1;
    bus.acc_bypass  = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = 32'h0;
    read_done  = 4'b0000;
    write_done = 4'b0000;
    done_ack   = 1'b0;
    cyc(3);
    chk_all_zero("reset");
    chk("reset_ready", {31'd0, bus.instr_ready}, 32'h1);
    reset = 1'b1;
    cyc(1);

    // Basic job on channel 2 via WRITE state
    push_en(2'd2);
    send(32'hFC00_0002);
    chk("t1_en_latency", {28'd0, acc_enable}, 32'h4);
    chk("t1_busy", {31'd0, busy}, 32'h1);
    chk("t1_not_ready", {31'd0, bus.instr_ready}, 32'h0);
    read_done = 4'b0100;
    cyc(1);
    read_done = 4'b0000;
    chk("t1_write_en", {28'd0, acc_enable}, 32'h4);
    chk("t1_write_busy", {31'd0, busy}, 32'h1);
    push_done(8'd1);
    write_done = 4'b0100;
    cyc(1);
    write_done = 4'b0000;
    chk("t1_done", {31'd0, acc_done}, 32'h1);
    cyc(3);
    chk("t1_done_held", {31'd0, acc_done}, 32'h1);
    done_ack = 1'b1;
    cyc(1);
    done_ack = 1'b0;
    chk("t1_ack_done", {31'd0, acc_done}, 32'h0);
    chk("t1_ack_ready", {31'd0, bus.instr_ready}, 32'h1);

    // Rejected instructions: bad opcode, index 5, reserved bit, bypass low
    push_err(1'b0);
    send(32'hF800_0002);
    chk("t2_err_pulse", {31'd0, err}, 32'h1);
    cyc(1);
    chk("t2_err_clear", {31'd0, err}, 32'h0);
    chk("t2_idle", {31'd0, bus.instr_ready}, 32'h1);
    push_err(1'b0);
    send(32'hFC00_0005);
    push_err(1'b0);
    send(32'hFC00_0100);
    bus.acc_bypass = 1'b0;
    push_err(1'b0);
    send(32'hFC00_0001);
    bus.acc_bypass = 1'b1;
    cyc(1);
    chk("t2_en_zero", {28'd0, acc_enable}, 32'h0);

    // Second instruction and foreign-channel completions ignored while busy
    push_en(2'd1);
    send(32'hFC00_0001);
    send(32'hFC00_0003);
    chk("t3_en_kept", {28'd0, acc_enable}, 32'h2);
    read_done  = 4'b1000;
    write_done = 4'b1000;
    cyc(2);
    read_done  = 4'b0000;
    write_done = 4'b0000;
    chk("t3_still_en", {28'd0, acc_enable}, 32'h2);
    chk("t3_still_busy", {31'd0, busy}, 32'h1);
    chk("t3_idx", {30'd0, active_idx}, 32'h1);
    push_done(8'd2);
    read_done  = 4'b0010;
    write_done = 4'b0010;
    cyc(1);
    read_done  = 4'b0000;
    write_done = 4'b0000;
    chk("t3_one_step_done", {31'd0, acc_done}, 32'h1);
    done_ack = 1'b1;
    cyc(1);
    done_ack = 1'b0;

    // Write before read on channel 0 is a protocol error
    push_en(2'd0);
    send(32'hFC00_0000);
    push_err(1'b0);
    write_done = 4'b0001;
    cyc(1);
    write_done = 4'b0000;
    chk("t4_err", {31'd0, err}, 32'h1);
    chk("t4_en_off", {28'd0, acc_enable}, 32'h0);
    chk("t4_no_done", {31'd0, acc_done}, 32'h0);
    chk("t4_cnt_same", {24'd0, done_count}, 32'h2);
    cyc(1);
    chk("t4_err_clear", {31'd0, err}, 32'h0);

    // Stalled job: watchdog abort when enabled, otherwise held indefinitely
    push_en(2'd0);
    send(32'hFC00_0000);
`ifdef ACC_DISPATCH_TIMEOUT_EN
    push_err(1'b1);
    cyc(15);
    chk("t6_en_before", {28'd0, acc_enable}, 32'h1);
    cyc(1);
    chk("t6_en_dropped", {28'd0, acc_enable}, 32'h0);
    chk("t6_err", {31'd0, err}, 32'h1);
    cyc(3);
    chk("t6_tmo_sticky", {31'd0, timeout_err}, 32'h1);
`else
    cyc(40);
    chk("t6_en_held", {28'd0, acc_enable}, 32'h1);
    chk("t6_no_tmo", {31'd0, timeout_err}, 32'h0);
`endif
    bus.chipselect = 1'b0;
    cyc(1);
    bus.chipselect = 1'b1;
    chk("t6_cs_tmo_clear", {31'd0, timeout_err}, 32'h0);
    chk("t6_cs_en", {28'd0, acc_enable}, 32'h0);

    // Reset during WRITE and chipselect low during RUN abort the job
    run_job(2'd1, 8'd1);
    push_en(2'd2);
    send(32'hFC00_0002);
    read_done = 4'b0100;
    cyc(1);
    read_done = 4'b0000;
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk_all_zero("t5_rst");
    run_job(2'd3, 8'd1);
    push_en(2'd3);
    send(32'hFC00_0003);
    bus.chipselect = 1'b0;
    cyc(1);
    bus.chipselect = 1'b1;
    chk_all_zero("t5_cs");
    chk("t5_cs_ready", {31'd0, bus.instr_ready}, 32'h1);

    // Counter wrap 255 -> 0
    for (int i = 1; i <= 256; i++) begin
      run_job(2'(i % 4), 8'(i));
      if (i == 255) chk("t5_cnt_255", {24'd0, done_count}, 32'hFF);
    end
    chk("t5_cnt_wrap", {24'd0, done_count}, 32'h0);

    cyc(3);
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
